// File: rtl/remote_pkg.sv
// Shared constants, state type and bit helpers for the IR remote keypad encoder.
// Used by remote_debounce and remote_keypad_encoder.
package remote_pkg;

    localparam int unsigned NUM_KEYS     = 8;
    localparam logic [7:0]  SAMSUNG_ADDR = 8'h07;

    // Samsung command codes, indexed by keypad bit: power, vol+, vol-, ch+, ch-, mute, source, menu.
    localparam logic [7:0] KEY_CODES [NUM_KEYS] = '{
        8'h02, 8'h07, 8'h0B, 8'h12, 8'h10, 8'h0F, 8'h01, 8'h1A
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        HELD = 2'd3
    } encoder_state_t;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

    // The transmitter shifts MSB first while Samsung puts each byte on air LSB first.
    function automatic logic [31:0] samsung_frame(input logic [7:0] code);
        return {rev8(SAMSUNG_ADDR), rev8(SAMSUNG_ADDR), rev8(code), rev8(~code)};
    endfunction

endpackage

// File: rtl/remote_debounce.sv
// Two-flop synchronizer followed by a stability counter; the output vector only
// follows the synchronized input after CYCLES consecutive unchanged cycles.
module remote_debounce #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned CYCLES = 500_000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam logic [31:0] CNT_LAST = 32'(CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [31:0]      cnt_q;
    logic [31:0]      cnt_d;

    // cnt_q saturates at CNT_LAST, meaning sync2_q has held for CYCLES cycles.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
        end
        if (sync1_q != sync2_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= din;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout = stable_q;

endmodule

// File: rtl/remote_keypad_encoder.sv
// Keypad front end for the Samsung IR transmitter: debounce, lowest-index key wins,
// frame build and frame-spacing FSM. Define REMOTE_REPEAT_EN to enable auto-repeat.
module remote_keypad_encoder
    import remote_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES  = 500_000,
    parameter int unsigned FRAME_GAP_CYCLES = 4_200_000,
    parameter int unsigned REPEAT_CYCLES    = 5_400_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  keys,
    output logic [31:0] command_out,
    output logic        busy
);

    localparam logic [31:0] GAP_LAST = 32'(FRAME_GAP_CYCLES - 1);

    if (DEBOUNCE_CYCLES == 0 || FRAME_GAP_CYCLES == 0 || REPEAT_CYCLES == 0) begin : g_param_check
        $error("remote_keypad_encoder: cycle parameters must be at least 1");
    end

`ifdef REMOTE_REPEAT_EN
    localparam logic [31:0] REP_LAST = 32'(REPEAT_CYCLES - 1);

    if (REPEAT_CYCLES < FRAME_GAP_CYCLES) begin : g_repeat_check
        $error("remote_keypad_encoder: REPEAT_CYCLES must be >= FRAME_GAP_CYCLES");
    end
`endif

    logic [7:0]     deb_keys;
    logic           win_valid;
    logic [2:0]     win_idx;

    encoder_state_t state_q, state_d;
    logic [2:0]     idx_q, idx_d;
    logic [31:0]    gap_q, gap_d;
    logic           busy_q, busy_d;
    logic [31:0]    cmd_q, cmd_d;
`ifdef REMOTE_REPEAT_EN
    logic [31:0]    rep_q, rep_d;
    logic           lock_q, lock_d;
`endif

    remote_debounce #(
        .WIDTH  (8),
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (keys),
        .dout    (deb_keys)
    );

    // Scan from the top so the lowest set bit is the last to assign.
    always_comb begin
        win_valid = |deb_keys;
        win_idx   = '0;
        for (int i = 7; i >= 0; i--) begin
            if (deb_keys[i]) begin
                win_idx = 3'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        busy_d  = busy_q;
        cmd_d   = '0;
`ifdef REMOTE_REPEAT_EN
        rep_d   = rep_q;
        lock_d  = lock_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    idx_d   = win_idx;
                    state_d = SEND;
                end
            end
            SEND: begin
                cmd_d   = samsung_frame(KEY_CODES[idx_q]);
                busy_d  = 1'b1;
                gap_d   = GAP_LAST;
                state_d = GAP;
`ifdef REMOTE_REPEAT_EN
                rep_d   = 32'd1;
                lock_d  = 1'b0;
`endif
            end
            GAP: begin
                if (gap_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = HELD;
                end else begin
                    gap_d = gap_q - 32'd1;
                end
            end
            HELD: begin
                if (!win_valid) begin
                    state_d = IDLE;
                end
`ifdef REMOTE_REPEAT_EN
                else if (!lock_q && win_idx == idx_q && rep_q >= REP_LAST) begin
                    state_d = SEND;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
`ifdef REMOTE_REPEAT_EN
        // Repeat timing runs from the pulse; any change of winner blocks repeats until release.
        if (state_q == GAP || state_q == HELD) begin
            if (rep_q < REP_LAST) begin
                rep_d = rep_q + 32'd1;
            end
            if (win_valid && win_idx != idx_q) begin
                lock_d = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
            busy_q  <= 1'b0;
            cmd_q   <= '0;
`ifdef REMOTE_REPEAT_EN
            rep_q   <= '0;
            lock_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            busy_q  <= busy_d;
            cmd_q   <= cmd_d;
`ifdef REMOTE_REPEAT_EN
            rep_q   <= rep_d;
            lock_q  <= lock_d;
`endif
        end
    end

    assign command_out = cmd_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_remote_keypad_encoder.sv
// Self-checking bench for remote_keypad_encoder: event-level reference model,
// directed scenarios with literal expectations, then randomized key activity.
module tb_remote_keypad_encoder;

    localparam int D = 4;
    localparam int G = 20;
    localparam int R = 30;
`ifdef REMOTE_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  keys = 8'h00;
    logic [31:0] command_out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    remote_keypad_encoder #(
        .DEBOUNCE_CYCLES  (D),
        .FRAME_GAP_CYCLES (G),
        .REPEAT_CYCLES    (R)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .keys        (keys),
        .command_out (command_out),
        .busy        (busy)
    );

    logic [7:0] codes [8] = '{8'h02, 8'h07, 8'h0B, 8'h12, 8'h10, 8'h0F, 8'h01, 8'h1A};

    // Bytes go on air address, address, code, ~code, each LSB first; the frame word is that bit stream MSB first.
    function automatic logic [31:0] frame_of(input int idx);
        logic [7:0]  seq [4];
        logic [31:0] f;
        seq[0] = 8'h07;
        seq[1] = 8'h07;
        seq[2] = codes[idx];
        seq[3] = ~codes[idx];
        f = '0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 8; j++) begin
                f = {f[30:0], seq[k][j]};
            end
        end
        return f;
    endfunction

    function automatic int lowest_set(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Reference model state: edge_n counts posedges; a pulse "at edge p" is visible right after edge p.
    int          edge_n = 0;
    logic [7:0]  m_s1, m_s2, m_deb;
    int          m_run;
    bit          m_armed, m_pend, m_lock;
    int          m_last_p;
    int          m_idx;
    logic [31:0] exp_cmd;
    logic        exp_busy;

    task automatic model_reset();
        m_s1 = 8'h00; m_s2 = 8'h00; m_deb = 8'h00; m_run = 1;
        m_armed = 1'b1; m_pend = 1'b0; m_lock = 1'b0;
        m_last_p = -1000000; m_idx = 0;
        exp_cmd = 32'h0; exp_busy = 1'b0;
    endtask

    task automatic model_step();
        bit new_pend;
        int w;
        edge_n++;
        new_pend = 1'b0;
        w = lowest_set(m_deb);
        if (m_pend) begin
            m_last_p = edge_n;
            exp_cmd  = frame_of(m_idx);
            m_lock   = 1'b0;
        end else begin
            exp_cmd = 32'h0;
            if (m_armed) begin
                if (m_deb != 0) begin
                    m_armed = 1'b0;
                    m_idx = w;
                    new_pend = 1'b1;
                end
            end else begin
                if (edge_n >= m_last_p + G + 1) begin
                    if (m_deb == 0) m_armed = 1'b1;
                    else if (REPEAT_ON && !m_lock && w == m_idx && edge_n - m_last_p >= R - 1) new_pend = 1'b1;
                end
                if (m_deb != 0 && w != m_idx) m_lock = 1'b1;
            end
        end
        exp_busy = (edge_n >= m_last_p) && (edge_n < m_last_p + G);
        if (m_run >= D) m_deb = m_s2;
        if (m_s1 == m_s2) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_run = 1;
        end
        m_s2 = m_s1;
        m_s1 = keys;
        m_pend = new_pend;
    endtask

    initial begin : model
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    // Observed pulses, busy-high count and spacing between consecutive pulses within one reset epoch.
    logic [31:0] pulse_val [$];
    int          pulse_edge [$];
    int          busy_cnt = 0;
    int          min_gap = 1000000;
    int          prev_pulse = -1;

    initial begin : compare
        forever begin
            @(negedge clk);
            checks++;
            if (command_out !== exp_cmd) begin
                errors++;
                $display("FAIL command_out edge %0d got %h want %h", edge_n, command_out, exp_cmd);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL busy edge %0d got %b want %b", edge_n, busy, exp_busy);
            end
            if (!reset_n) begin
                prev_pulse = -1;
            end else begin
                if (busy === 1'b1) busy_cnt++;
                if (command_out != 32'h0) begin
                    pulse_val.push_back(command_out);
                    pulse_edge.push_back(edge_n);
                    if (prev_pulse >= 0 && edge_n - prev_pulse < min_gap) min_gap = edge_n - prev_pulse;
                    prev_pulse = edge_n;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stim
        int base, t0, n, r;
        cyc(3);
        reset_n = 1'b1;
        cyc(2);
        check("reset_cmd", command_out, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);

        // Single press of power
        base = pulse_val.size(); busy_cnt = 0; t0 = edge_n;
        keys = 8'h01; cyc(40); keys = 8'h00; cyc(15);
        check("t1_count", pulse_val.size() - base, 1);
        if (pulse_val.size() > base) begin
            check("t1_value", pulse_val[base], 32'hE0E040BF);
            check("t1_latency", pulse_edge[base] - t0, D + 4);
        end
        check("t1_busy_len", busy_cnt, G);

        // Bouncing vol+ then stable
        base = pulse_val.size();
        for (int i = 0; i < 12; i++) begin
            keys = (i % 2 == 0) ? 8'h02 : 8'h00;
            cyc(1);
        end
        check("t2_no_bounce_pulse", pulse_val.size() - base, 0);
        t0 = edge_n; keys = 8'h02; cyc(30);
        check("t2_count", pulse_val.size() - base, 1);
        if (pulse_val.size() > base) begin
            check("t2_value", pulse_val[base], 32'hE0E0E01F);
            check("t2_latency", pulse_edge[base] - t0, D + 4);
        end
        keys = 8'h00; cyc(20);

        // Two keys: lowest index wins; rollover to another key sends nothing
        base = pulse_val.size();
        keys = 8'h06; cyc(35);
        check("t3_count", pulse_val.size() - base, 1);
        if (pulse_val.size() > base) check("t3_value", pulse_val[base], 32'hE0E0E01F);
        keys = 8'h04; cyc(40);
        check("t3_no_rollover", pulse_val.size() - base, 1);
        keys = 8'h00; cyc(20);

        // Release at gap cycle 5, re-press at gap cycle 12
        base = pulse_val.size();
        keys = 8'h01; cyc(D + 4);
        cyc(5); keys = 8'h00;
        cyc(7); keys = 8'h01;
        cyc(30);
        check("t4_first", pulse_val.size() - base >= 1, 1);
        if (pulse_val.size() - base >= 2) check("t4_spacing_ok", pulse_edge[base+1] - pulse_edge[base] >= G + 1, 1);
        keys = 8'h00; cyc(20);

        // Reset in the middle of GAP with the key still held
        base = pulse_val.size();
        keys = 8'h08; cyc(D + 4);
        check("t5_first", pulse_val.size() - base, 1);
        cyc(5);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("t5_reset_cmd", command_out, 32'h0);
        check("t5_reset_busy", {31'h0, busy}, 32'h0);
        cyc(2);
        reset_n = 1'b1;
        base = pulse_val.size(); t0 = edge_n;
        cyc(30);
        check("t5_after_reset_count", pulse_val.size() - base, 1);
        if (pulse_val.size() > base) begin
            check("t5_after_reset_value", pulse_val[base], 32'hE0E048B7);
            check("t5_after_reset_latency", pulse_edge[base] - t0, D + 4);
        end
        keys = 8'h00; cyc(20);

        // Long hold: repeats every R cycles only when auto-repeat is built in
        base = pulse_val.size();
        keys = 8'h01; cyc(100); keys = 8'h00; cyc(40);
        check("t6_count", pulse_val.size() - base, REPEAT_ON ? 4 : 1);
        if (pulse_val.size() - base >= 2) check("t6_period", pulse_edge[base+1] - pulse_edge[base], R);

        // Randomized key activity with occasional resets
        for (int s = 0; s < 150; s++) begin
            r = $urandom_range(0, 9);
            n = $urandom_range(1, 40);
            if (r <= 3) keys = 8'h00;
            else if (r <= 6) keys = 8'(1 << $urandom_range(0, 7));
            else if (r <= 8) keys = 8'($urandom_range(0, 255));
            else begin
                reset_n = 1'b0;
                cyc($urandom_range(1, 3));
                reset_n = 1'b1;
            end
            cyc(n);
        end
        keys = 8'h00; cyc(40);

        check("min_pulse_spacing", min_gap >= G + 1, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/remote_keypad_encoder.md
# remote_keypad_encoder

Upstream stage of the IR remote transmit path. Debounces an 8-button keypad, maps the winning key to a Samsung 32-bit frame (address, address, command, inverted command) and drives `command_out` into the Samsung protocol transmitter as a single-cycle nonzero pulse. The transmitter has no busy/ready output, so this block enforces frame spacing itself and never issues a new command while a frame may still be on air.

## Interface
- `DEBOUNCE_CYCLES`, 500_000: cycles a key vector must be stable before it is accepted (10 ms at 50 MHz).
- `FRAME_GAP_CYCLES`, 4_200_000: minimum cycles from a command pulse to the next; covers a worst-case all-ones frame plus margin.
- `REPEAT_CYCLES`, 5_400_000: auto-repeat period while a key is held (108 ms); used only with `REMOTE_REPEAT_EN`.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `keys`  in  8  raw button levels, active-high, asynchronous to `clk`.
- `command_out`  out  32  frame to the transmitter; nonzero for exactly one cycle per frame, 0 otherwise.
- `busy`  out  1  high from the command pulse until the gap expires.

## Operation
- `keys` passes through a 2-flop synchronizer, then debouncing. The debounced vector updates only after `DEBOUNCE_CYCLES` consecutive cycles with an unchanged synchronized vector; any change restarts the count.
- Key selection: the lowest-index set bit of the debounced vector wins. Codes are 0x02 (power), 0x07 (vol+), 0x0B (vol−), 0x12 (ch+), 0x10 (ch−), 0x0F (mute), 0x01 (source), 0x1A (menu), for bits 0 through 7. The address is 0x07.
- Frame: {rev8(ADDR), rev8(ADDR), rev8(code), rev8(~code)}. `rev8` reverses the bits within each byte, because the transmitter shifts out the MSB first and Samsung sends each byte LSB first. Examples: power = 0xE0E040BF; vol+ = 0xE0E0E01F.
- States:
  - IDLE → SEND when the debounced vector becomes nonzero.
  - SEND: one cycle. Drives the frame, sets `busy`, and loads the gap counter → GAP.
  - GAP: counts `FRAME_GAP_CYCLES`. At expiry, `busy` drops → HELD.
  - HELD: waits until the debounced vector is zero → IDLE.
- No rollover: pressing a different key while one is held does not produce a frame until all keys are released and a key is pressed again.
- Press and release during GAP: the release is observed in HELD and the block returns to IDLE; no extra frame is sent.

## Timing
- Reset values: `command_out` = 0, `busy` = 0, state = IDLE, all counters = 0, debounced vector = 0. Assertion is asynchronous; deassertion is used synchronously via `clk`.
- Latency from a raw key edge to the `command_out` pulse is 2 (sync) + `DEBOUNCE_CYCLES` + 1 (register) + 1 (SEND) cycles.
- `busy` rises in the same cycle as the pulse and stays high for exactly `FRAME_GAP_CYCLES` cycles.
- Consecutive pulse edges are never closer than `FRAME_GAP_CYCLES` + 1 cycles.
- Reset mid-GAP aborts silently. After release of reset, a still-held key must re-debounce before a new frame is sent.
- Counters are 32-bit unsigned and never wrap within a parameter range; parameters must be ≥ 1.

## Configuration
- `REMOTE_REPEAT_EN` defined: in HELD, a repeat counter runs. Each time it reaches `REPEAT_CYCLES` with the same key still winning, the block re-enters SEND with the same frame. A change of the winning key does not repeat; the block waits for release. `REPEAT_CYCLES` must be ≥ `FRAME_GAP_CYCLES`; this is checked with an elaboration-time assertion.
- `REMOTE_REPEAT_EN` undefined: exactly one frame per press. The repeat counter and its logic are absent.

## Structure
- Package `remote_pkg` holds:
  - `SAMSUNG_ADDR` and the 8-entry key-code constant array.
  - The `encoder_state_t` enum (IDLE, SEND, GAP, HELD).
  - The `rev8` function.
- Sub-module `remote_debounce` (parameter WIDTH, CYCLES) contains the synchronizer and the stability counter, and outputs the debounced vector.
- The top level contains the priority encoder, the frame builder and the FSM.

## Test plan
- Run with small parameters: DEBOUNCE_CYCLES=4, FRAME_GAP_CYCLES=20, REPEAT_CYCLES=30.
- Press `keys`=0x01 for 40 cycles → one pulse `command_out`=0xE0E040BF, `busy` high for 20 cycles, no second pulse.
- Toggle `keys`[1] at a 2-cycle period for 12 cycles, then hold high → no pulse during bouncing; exactly one 0xE0E0E01F after a stable 4 cycles.
- Hold `keys`=0x06 → the frame is for bit 1 only (0xE0E0E01F). Then change to 0x04 without release → no new frame.
- Press, release at GAP cycle 5, press the same key at GAP cycle 12 → the second frame appears no earlier than 21 cycles after the first.
- Assert `reset_n` low mid-GAP → `command_out`=0 and `busy`=0 immediately. With the key still held after reset, a new frame is sent after re-debounce.
- With `REMOTE_REPEAT_EN`: hold `keys`=0x01 → 0xE0E040BF pulses every 30 cycles; release stops repeats.
